dds_ctrl: RTL
=============

# dds_ctrl

Sequencer in front of the `dds` datapath. Divides the system clock into an audio sample-rate tick and accepts note-on/note-off events over a valid/ready handshake. Applies note changes only on sample boundaries, respecting the DDS lookup latencies, and then issues one sine query per tick. Delivers each captured sample, gated by note state, to the downstream mixer/serializer over a valid/ready output with overrun detection.

## Interface
- `DATA_WDTH`, 24: sample width; matches `dds` sine output.
- `NOTE_WDTH`, 7: note index width; matches the `dds` note lookup address.
- `DIV_WDTH`, 12: width of the sample-tick counter.
- `SAMPLE_DIV`, 256: clock cycles per sample tick; legal range 16..2^DIV_WDTH.

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `note_valid`  in  1  note event offered.
- `note_ready`  out  1  pending-event slot empty.
- `note_on`  in  1  1 = note-on (change pitch, gate open); 0 = note-off (gate closed).
- `note_num`  in  NOTE_WDTH  note index; ignored when `note_on` = 0.
- `dds_change_note`  out  1  one-cycle strobe to `dds`.
- `dds_note`  out  NOTE_WDTH  note index to `dds`; valid with the strobe.
- `dds_query_sine`  out  1  one-cycle phase-advance/query strobe to `dds`.
- `dds_sine`  in  DATA_WDTH  registered sine value from `dds`.
- `smp_valid`  out  1  output sample available.
- `smp_ready`  in  1  downstream accepts the sample.
- `smp_data`  out  DATA_WDTH  output sample, two's complement.
- `overrun`  out  1  sticky: an unconsumed sample was overwritten.

## Operation
- Tick counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - `tick` is high for one cycle when count = SAMPLE_DIV-1.
- Note slot (one entry):
  - An event is accepted when `note_valid && note_ready`. This latches `note_on` and `note_num` and sets `pending`.
  - `note_ready` = !`pending`.
  - The slot is consumed at the next tick and `note_ready` rises the cycle after consumption.
  - Events arriving between ticks wait; at most one event is applied per tick.
- FSM states: IDLE, CHG, SETTLE, QRY, WAIT, CAP.
  - IDLE: on `tick`, go to CHG if `pending` and `note_on` is latched. Otherwise go to QRY; for a pending note-off, clear `gate` and `pending` on the same edge.
  - CHG (1 cycle): `dds_change_note` = 1 and `dds_note` = latched note. Set `gate` = 1 and clear `pending`. Go to SETTLE.
  - SETTLE (2 cycles, DDS_NOTE_LAT): idle outputs. Go to QRY.
  - QRY (1 cycle): `dds_query_sine` = 1. Go to WAIT.
  - WAIT (2 cycles): go to CAP.
  - CAP (1 cycle): sample `dds_sine`, which is valid 3 cycles after the query (DDS_SINE_LAT). Load `smp_data` = `gate` ? `dds_sine` : 0. Set `smp_valid` and go to IDLE.
- The query is issued every tick regardless of gate, so DDS phase stays continuous.
- Output register:
  - `smp_valid` stays high until `smp_valid && smp_ready`, then drops on the next edge.
  - Load in CAP while `smp_valid` = 1 and `smp_ready` = 0: overwrite `smp_data`, keep `smp_valid` = 1, set `overrun`.
  - Load in CAP in the same cycle as a handshake: the new sample wins, `smp_valid` stays 1, and no overrun is flagged.
- `overrun` clears only on reset.
- SAMPLE_DIV ≥ 16 guarantees the FSM is in IDLE at every tick. A tick seen outside IDLE is a design error; the bench asserts on it.
- Reset (asynchronous, at any time including mid-sequence):
  - State = IDLE, counter = 0, `pending` = 0, `gate` = 0.
  - All outputs are 0, except `note_ready`, which is 1.

## Timing
- Tick at cycle T, no pending event: QRY at T+1, CAP at T+4, `smp_valid` high from T+5.
- Tick at T, pending note-on: CHG at T+1, SETTLE at T+2 and T+3, QRY at T+4, CAP at T+7, `smp_valid` high from T+8.
- First tick after reset release: count reaches SAMPLE_DIV-1 in cycle SAMPLE_DIV-1.
- Note accept to `dds_change_note`: between 2 and SAMPLE_DIV+1 cycles.
- Note-off affects the sample captured in the same tick sequence.
- `dds_change_note` and `dds_query_sine` are never high in the same cycle, and each is at most one cycle wide.

## Structure
- Package `dds_ctrl_pkg` contains:
  - FSM state enum.
  - DDS_NOTE_LAT = 2 and DDS_SINE_LAT = 3, shared with `dds` and any other `dds` client.
  - Default DATA_WDTH and NOTE_WDTH.
- Sub-module `sample_tick_gen`: a parameterized DIV_WDTH/SAMPLE_DIV counter that outputs `tick`, with the same `clk`/`rst_n`.
- The FSM, note slot and output register stay in `dds_ctrl`.

## Test plan
- Reset, then idle with `smp_ready` = 1 and SAMPLE_DIV = 16: `dds_query_sine` pulses at cycles 16, 32, ...; `smp_data` = 0 (gate closed); `dds_change_note` never pulses.
- Note-on with `note_num` = 69 accepted at cycle 3: `note_ready` is 0 until the consume point. `dds_change_note` with `dds_note` = 69 at T+1, query at T+4, and `smp_data` = `dds_sine` with `smp_valid` at T+8.
- Note-on, then note-off two ticks later: the output follows `dds_sine`, then reads 0 from that tick on, with no change strobe for the note-off.
- Two note events back-to-back: the second is stalled (`note_ready` = 0) until the first is consumed; each event is applied on successive ticks.
- `smp_ready` held at 0 for three ticks: `smp_valid` stays 1, `smp_data` holds the newest sample, and `overrun` rises at the second capture and stays set.
- `rst_n` asserted during SETTLE: all outputs are immediately 0 and `note_ready` = 1. After release the first query comes at cycle SAMPLE_DIV and no stale change strobe is issued.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: shared DDS latencies, default widths and sequencer states
package dds_ctrl_pkg;
    localparam int DDS_NOTE_LAT = 2;
    localparam int DDS_SINE_LAT = 3;
    localparam int DEF_DATA_WDTH = 24;
    localparam int DEF_NOTE_WDTH = 7;
    typedef enum logic [2:0] {IDLE, CHG, SETTLE, QRY, WAIT, CAP} state_t;
endpackage

// File: rtl/dds_ctrl_tick.sv
// sample_tick_gen: wrapping divider that strobes tick on the last count of each sample period
module sample_tick_gen #(
    parameter int DIV_WDTH = 12,
    parameter int SAMPLE_DIV = 256
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam logic [DIV_WDTH-1:0] LAST = DIV_WDTH'(SAMPLE_DIV - 1);
    logic [DIV_WDTH-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= tick ? '0 : cnt + DIV_WDTH'(1);
    end
endmodule

// File: rtl/dds_ctrl.sv
// dds_ctrl: sample-rate sequencer for the dds datapath; applies note events on ticks,
// issues one sine query per tick and hands gated samples downstream.
module dds_ctrl import dds_ctrl_pkg::*; #(
    parameter int DATA_WDTH = DEF_DATA_WDTH,
    parameter int NOTE_WDTH = DEF_NOTE_WDTH,
    parameter int DIV_WDTH = 12,
    parameter int SAMPLE_DIV = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 note_valid,
    output logic                 note_ready,
    input  logic                 note_on,
    input  logic [NOTE_WDTH-1:0] note_num,
    output logic                 dds_change_note,
    output logic [NOTE_WDTH-1:0] dds_note,
    output logic                 dds_query_sine,
    input  logic [DATA_WDTH-1:0] dds_sine,
    output logic                 smp_valid,
    input  logic                 smp_ready,
    output logic [DATA_WDTH-1:0] smp_data,
    output logic                 overrun
);
    state_t state;
    logic tick, pending, lat_on, gate;
    logic [NOTE_WDTH-1:0] lat_num;
    logic [1:0] sub;

    sample_tick_gen #(.DIV_WDTH(DIV_WDTH), .SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk(clk), .rst_n(rst_n), .tick(tick)
    );

    assign note_ready = !pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sub <= '0;
            pending <= 1'b0;
            lat_on <= 1'b0;
            lat_num <= '0;
            gate <= 1'b0;
            dds_change_note <= 1'b0;
            dds_note <= '0;
            dds_query_sine <= 1'b0;
            smp_valid <= 1'b0;
            smp_data <= '0;
            overrun <= 1'b0;
        end else begin
            if (note_valid && !pending) begin
                pending <= 1'b1;
                lat_on <= note_on;
                lat_num <= note_num;
            end
            if (smp_valid && smp_ready) smp_valid <= 1'b0;
            case (state)
                IDLE: if (tick) begin
                    if (pending && lat_on) begin
                        state <= CHG;
                        dds_change_note <= 1'b1;
                        dds_note <= lat_num;
                    end else begin
                        // note-off needs no dds update, only the gate closes
                        state <= QRY;
                        dds_query_sine <= 1'b1;
                        if (pending) begin
                            gate <= 1'b0;
                            pending <= 1'b0;
                        end
                    end
                end
                CHG: begin
                    dds_change_note <= 1'b0;
                    dds_note <= '0;
                    gate <= 1'b1;
                    pending <= 1'b0;
                    sub <= '0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    sub <= sub + 2'd1;
                    if (sub == 2'(DDS_NOTE_LAT - 1)) begin
                        state <= QRY;
                        dds_query_sine <= 1'b1;
                    end
                end
                QRY: begin
                    dds_query_sine <= 1'b0;
                    sub <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    sub <= sub + 2'd1;
                    if (sub == 2'(DDS_SINE_LAT - 2)) state <= CAP;
                end
                CAP: begin
                    smp_data <= gate ? dds_sine : '0;
                    smp_valid <= 1'b1;
                    if (smp_valid && !smp_ready) overrun <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
